uart_rx_16x: RTL and testbench
==============================

# uart_rx_16x

8-N-1 UART receiver for the Bluetooth serial link. It consumes the 16× oversampling strobe `rxclk_en` from the baud-rate generator and validates the start bit at its midpoint. It samples each data bit at its midpoint and presents the received byte with a sticky ready flag and error flags to the downstream command logic. The block sits between the module's RX pad and the command decoder, in the `clk_50m` domain.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `SYNC_STAGES`, 2: flip-flops in the `rx` input synchronizer (minimum 2).
- `clk_50m` input 1: system clock, 50 MHz.
- `rst_n` input 1: reset, asynchronous assert, active-low. This is the block's only reset; there is one clock.
- `rxclk_en` input 1: one-`clk_50m`-cycle strobe at 16× baud (9600 × 16).
- `rx` input 1: asynchronous serial line. Idles high.
- `rd_clr` input 1: one-cycle pulse from the consumer. Clears `rdy`, `frame_err` and `overrun`.
- `data` output DATA_BITS: last received byte.
- `rdy` output 1: sticky. A completed frame is waiting.
- `frame_err` output 1: sticky. The last frame's stop bit sampled low.
- `overrun` output 1: sticky. A frame completed while `rdy` was still 1.
- `busy` output 1: the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through SYNC_STAGES flops, each resetting to 1. All logic uses the synchronized value `rx_s`.
- **State and counters:** the FSM state and two counters advance only on cycles where `rxclk_en`=1. The sample counter `tick` is 4 bits and wraps 15→0. The bit counter `bitn` counts 0..DATA_BITS-1.
- **IDLE:** `tick`=0. When `rx_s`=0 on a strobe, go to START with `tick`=1.
- **START:** increment `tick` on each strobe.
  - If `rx_s`=1 on any strobe before `tick` reaches 8, treat it as a false start: return to IDLE with nothing latched.
  - At `tick`=8 with `rx_s`=0, clear `tick` to 0 and `bitn` to 0, then go to DATA. This re-centres the sample point on the bit midpoint.
- **DATA:** on the strobe where `tick`=15, shift `rx_s` into the MSB of a shift register (LSB arrives first).
  - If `bitn`=DATA_BITS-1, go to STOP. Otherwise increment `bitn`.
  - Every sample lands 16 strobes after the previous one.
- **STOP:** on the strobe where `tick`=15, sample the stop bit, update the outputs as below, and return to IDLE.
  - Stop bit = 1: load `data` from the shift register and set `rdy`=1. If `rdy` was already 1, also set `overrun`=1.
  - Stop bit = 0: load `data` and set `frame_err`=1. `rdy` is not changed.
- **Flag clear:** `rd_clr`=1 clears `rdy`, `frame_err` and `overrun` on that cycle.
  - If `rd_clr` coincides with a frame completion, the completion wins: the flags show the new frame.
  - In that coincident case `overrun` is not set, because the previous byte was read.
- **`data` stability:** `data` changes only at frame completion and holds otherwise.
- **`rxclk_en` low:** with `rxclk_en` held at 0 the FSM freezes. `rd_clr` remains effective.
- **Reset:** asserting `rst_n` low at any point, including mid-frame, aborts the frame immediately.

## Timing
- **Reset values:** state IDLE, `tick`=0, `bitn`=0, shift register 0, `data`=0, `rdy`=0, `frame_err`=0, `overrun`=0, `busy`=0, synchronizer all 1.
- **Input latency:** SYNC_STAGES `clk_50m` cycles from a `rx` edge to `rx_s`.
- **Start detection:** the start edge is seen on the first strobe after `rx_s` falls. This gives ±1 strobe (1/16 bit) of sampling jitter.
- **Output latency:** `rdy`, `frame_err`, `overrun` and `data` are registered. They update on the `clk_50m` edge that ends the stop-bit sampling strobe cycle.
- **Frame length:** 8 strobes after detection (start midpoint), then 16 × DATA_BITS + 16 more strobes. IDLE is re-entered half a bit before the nominal stop-bit end, so back-to-back frames with zero idle time are received.
- **`busy`:** `busy`=1 from the cycle after start detection through the stop-bit sampling cycle.
- **Clearing:** `rd_clr` takes effect on the next edge. Holding it high for multiple cycles is harmless.

## Test plan
- **Single byte:** with `rxclk_en` every 326 cycles, drive 0xA5 as 8-N-1 at 9600 baud. Required: `data`=0xA5, `rdy`=1, `frame_err`=0, `busy`=0 after completion. Then pulse `rd_clr`: `rdy`=0 on the next cycle, `data` still 0xA5.
- **Glitch rejection:** drive `rx` low for 4 strobes, then high. Required: return to IDLE, `rdy` stays 0, `data` unchanged, `busy` falls within 1 strobe of `rx_s` rising.
- **Framing error:** send 0x3C with the stop bit low. Required: `data`=0x3C, `frame_err`=1, `rdy`=0. The following good frame 0x55 gives `rdy`=1 with `frame_err` still 1 until `rd_clr`.
- **Overrun:** send back-to-back 0x01 and 0x02 with no `rd_clr` and zero idle time between them. Required: `data`=0x02, `rdy`=1, `overrun`=1. Repeating the sequence with `rd_clr` on the 0x02 completion cycle must give `overrun`=0 and `rdy`=1.
- **Mid-frame reset:** assert `rst_n`=0 during bit 4 of 0xFF. Required: all outputs return to their reset values asynchronously. After release, a fresh 0x81 is received correctly with no leftover bits.
- **Baud tolerance:** send 0x5A at +3% and −3% bit period. Required: received correctly both times with `frame_err`=0.

Source files
------------

// File: rtl/uart_rx_16x.sv
// Purpose: 8-N-1 UART receiver driven by a 16x oversampling strobe; start bit qualified at its midpoint, data bits sampled at their midpoints.
// Latency: SYNC_STAGES cycles from the rx pad to rx_s; data/flags update on the edge ending the stop-bit sampling strobe cycle.
// Backpressure: none, the line cannot be stalled; an unread byte is overwritten and flagged by the sticky overrun bit.
module uart_rx_16x #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 rxclk_en,
    input  logic                 rx,
    input  logic                 rd_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BITN_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchronizer chain, idles at 1 so reset never looks like a start bit.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   rx_s;

    state_t                 state_q,     state_d;
    logic [3:0]             tick_q,      tick_d;
    logic [BITN_W-1:0]      bitn_q,      bitn_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [DATA_BITS-1:0]   data_q,      data_d;
    logic                   rdy_q,       rdy_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Shift the raw pad value into the synchronizer.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    end

    // Next-state logic: FSM and counters move only on strobes; the flag clear acts every cycle.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bitn_d      = bitn_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rdy_d       = rd_clr ? 1'b0 : rdy_q;
        frame_err_d = rd_clr ? 1'b0 : frame_err_q;
        overrun_d   = rd_clr ? 1'b0 : overrun_q;

        if (rxclk_en) begin
            case (state_q)
                S_IDLE: begin
                    tick_d = 4'd0;
                    if (!rx_s) begin
                        state_d = S_START;
                        tick_d  = 4'd1;
                    end
                end
                S_START: begin
                    if (rx_s) begin
                        // Line went high before the start midpoint: treat as a glitch.
                        state_d = S_IDLE;
                        tick_d  = 4'd0;
                    end else if (tick_q == 4'd8) begin
                        // Start midpoint confirmed; restart the tick so later samples land mid-bit.
                        state_d = S_DATA;
                        tick_d  = 4'd0;
                        bitn_d  = '0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
                S_DATA: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bitn_q == BITN_LAST) begin
                            state_d = S_STOP;
                        end else begin
                            bitn_d = bitn_q + BITN_W'(1);
                        end
                    end
                end
                S_STOP: begin
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        state_d = S_IDLE;
                        tick_d  = 4'd0;
                        data_d  = shift_q;
                        if (rx_s) begin
                            rdy_d = 1'b1;
                            // A coincident clear means the previous byte was consumed.
                            if (rdy_q && !rd_clr) begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = 4'd0;
                end
            endcase
        end
    end

    // Register synchronizer, FSM, counters and outputs; reset aborts any frame in flight.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            tick_q      <= 4'd0;
            bitn_q      <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            rdy_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            tick_q      <= tick_d;
            bitn_q      <= bitn_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rdy_q       <= rdy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign rdy       = rdy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// Purpose: directed self-checking bench for uart_rx_16x; frames are driven cycle by cycle from one process.
// Latency: the strobe runs every DIV cycles so a full frame takes 10*16*DIV cycles.
// Backpressure: not applicable; rd_clr is pulsed on exact cycles where coincidence matters.
module tb_uart_rx_16x;

    localparam int DIV  = 4;
    localparam int BITC = 16 * DIV;

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        int         bitc;
        int         clr_idx;
        logic       do_chk;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_ferr;
        logic       exp_ovr;
        logic       clr_after;
    } vec_t;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       rxclk_en;
    logic       rx;
    logic       rd_clr;
    logic [7:0] data;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int cyc    = 0;
    bit en_run = 1'b1;
    int checks = 0;
    int errors = 0;

    uart_rx_16x #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .rxclk_en  (rxclk_en),
        .rx        (rx),
        .rd_clr    (rd_clr),
        .data      (data),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk_50m = ~clk_50m;

    // Advance one cycle; inputs are changed 1 ns after the edge, strobe on every DIV-th cycle.
    task automatic step();
        @(posedge clk_50m);
        #1;
        cyc      = cyc + 1;
        rxclk_en = en_run && (cyc % DIV == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            rx     = 1'b1;
            rd_clr = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        step();
        rd_clr = 1'b1;
        step();
        rd_clr = 1'b0;
    endtask

    // Drive one 8-N-1 frame. The start edge is placed so that the synchronized
    // edge lands on a strobe cycle: detection is then at index 2 and the stop
    // sample (completion) at index 2 + 4*152 = 610 of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int bitc,
                              input int clr_idx, input int max_cyc);
        while (cyc % DIV != 1) begin
            step();
        end
        for (int i = 0; i < 10 * bitc && i < max_cyc; i++) begin
            int idx;
            step();
            idx = i / bitc;
            if (idx == 0) begin
                rx = 1'b0;
            end else if (idx <= 8) begin
                rx = b[3'(idx - 1)];
            end else if (stop_v) begin
                rx = 1'b1;
            end else begin
                // A low stop bit recovers shortly after its midpoint sample.
                rx = (i < 9 * bitc + (bitc * 5) / 8) ? 1'b0 : 1'b1;
            end
            rd_clr = (i == clr_idx);
        end
        rd_clr = 1'b0;
    endtask

    initial begin
        vec_t vecs[9];

        rst_n    = 1'b0;
        rx       = 1'b1;
        rxclk_en = 1'b0;
        rd_clr   = 1'b0;

        //          byte    stop  bitc        clr  chk   data   rdy   ferr  ovr   clr_after
        vecs[0] = '{8'hA5, 1'b1, BITC,       -1,  1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, BITC,       -1,  1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h55, 1'b1, BITC,       -1,  1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 1'b1, BITC,       -1,  1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h02, 1'b1, BITC,       -1,  1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'h01, 1'b1, BITC,       -1,  1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h02, 1'b1, BITC,       610, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h5A, 1'b1, BITC + 2,   -1,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'h5A, 1'b1, BITC - 2,   -1,  1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset values.
        step();
        step();
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_rdy", 32'(rdy), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        idle(8);

        // Glitch: rx low for 4 strobes, then high.
        while (cyc % DIV != 1) begin
            step();
        end
        for (int i = 0; i < 24; i++) begin
            step();
            rx = (i < 16) ? 1'b0 : 1'b1;
            if (i == 10) chk("glitch_busy_during", 32'(busy), 32'h1);
            if (i == 22) chk("glitch_busy_after", 32'(busy), 32'h0);
        end
        idle(4);
        chk("glitch_rdy", 32'(rdy), 32'h0);
        chk("glitch_data", 32'(data), 32'h0);

        // Table of frames.
        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].byte_v, vecs[v].stop_v, vecs[v].bitc, vecs[v].clr_idx, 100000);
            if (vecs[v].do_chk) begin
                idle(8);
                chk($sformatf("v%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
                chk($sformatf("v%0d_rdy", v), 32'(rdy), 32'(vecs[v].exp_rdy));
                chk($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
                chk($sformatf("v%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
                chk($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
                if (vecs[v].clr_after) begin
                    pulse_clr();
                    chk($sformatf("v%0d_clr_rdy", v), 32'(rdy), 32'h0);
                    chk($sformatf("v%0d_clr_frame_err", v), 32'(frame_err), 32'h0);
                    chk($sformatf("v%0d_clr_overrun", v), 32'(overrun), 32'h0);
                    chk($sformatf("v%0d_clr_data", v), 32'(data), 32'(vecs[v].exp_data));
                end
            end
        end

        // Mid-frame reset during data bit 4 of 0xFF.
        send_frame(8'hFF, 1'b1, BITC, -1, 5 * BITC + BITC / 2);
        chk("midrst_busy_before", 32'(busy), 32'h1);
        chk("midrst_rdy_before", 32'(rdy), 32'h1);
        #5;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 32'(data), 32'h0);
        chk("midrst_rdy", 32'(rdy), 32'h0);
        chk("midrst_frame_err", 32'(frame_err), 32'h0);
        chk("midrst_overrun", 32'(overrun), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        idle(4);
        rst_n = 1'b1;
        idle(16);
        send_frame(8'h81, 1'b1, BITC, -1, 100000);
        idle(8);
        chk("after_rst_data", 32'(data), 32'h81);
        chk("after_rst_rdy", 32'(rdy), 32'h1);
        chk("after_rst_frame_err", 32'(frame_err), 32'h0);

        // Strobe held low: FSM frozen, clear still works.
        en_run = 1'b0;
        idle(2);
        pulse_clr();
        chk("frozen_clr_rdy", 32'(rdy), 32'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            rx = 1'b0;
        end
        chk("frozen_busy", 32'(busy), 32'h0);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
